nco_sweep_ctrl: RTL

- Sequencer that drives the NCO configuration inputs (frequency, wave, duty_cycle).
- Generates linear frequency sweeps (chirps) in Q32.32 from a start to a stop frequency, in fixed steps, with a programmable dwell time per step.
- Supports single-shot, repeating sawtooth and up/down bounce sweeps. Sits between the control/register layer and the NCO instance, in the same clock domain.

---
 rtl/nco_pkg.sv | 41 ++++
 rtl/nco_dwell_timer.sv | 28 ++
 rtl/nco_sweep_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared types and helpers for the NCO sweep controller and its sub-blocks.
package nco_pkg;

  localparam int unsigned FREQ_W = 64;  // Q32.32 unsigned frequency word

  typedef enum logic [1:0] {
    WaveSine     = 2'b00,
    WaveTriangle = 2'b01,
    WaveSawtooth = 2'b10,
    WaveSquare   = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    ModeSingle    = 2'b00,
    ModeRepeat    = 2'b01,
    ModeBounce    = 2'b10,
    ModeSingleAlt = 2'b11
  } mode_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StSweep = 1'b1
  } state_e;

  // One sweep step, clamped to the target on overshoot, carry or borrow.
  function automatic logic [FREQ_W-1:0] step_clamp(input logic [FREQ_W-1:0] cur,
                                                   input logic [FREQ_W-1:0] step,
                                                   input logic [FREQ_W-1:0] tgt,
                                                   input logic              up);
    logic [FREQ_W:0] sum;
    if (up) begin
      sum = {1'b0, cur} + {1'b0, step};
      if (sum[FREQ_W] || (sum[FREQ_W-1:0] >= tgt)) return tgt;
    end else begin
      sum = {1'b0, cur} - {1'b0, step};
      if (sum[FREQ_W] || (sum[FREQ_W-1:0] <= tgt)) return tgt;
    end
    return sum[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter; expire is high while enabled and the count has reached zero.
module nco_dwell_timer #(
  parameter int unsigned DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   enable,
  input  logic [DWELL_WIDTH-1:0] load_val,
  output logic                   expire
);

  logic [DWELL_WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - DWELL_WIDTH'(1);
    end
  end

  assign expire = enable && (count_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Chirp sequencer driving NCO frequency/wave/duty: single, sawtooth-repeat and bounce sweeps.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BIT_DEPTH   = 8,
  parameter int unsigned DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [FREQ_W-1:0]      f_start,
  input  logic [FREQ_W-1:0]      f_stop,
  input  logic [FREQ_W-1:0]      f_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [1:0]             wave_in,
  input  logic [BIT_DEPTH-1:0]   duty_in,
  output logic [FREQ_W-1:0]      frequency,
  output logic [1:0]             wave,
  output logic [BIT_DEPTH-1:0]   duty_cycle,
  output logic                   busy,
  output logic                   done,
  output logic                   step_tick
);

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [FREQ_W-1:0]      freq_q, freq_d, fstart_q, fstart_d, fstop_q, fstop_d;
  logic [FREQ_W-1:0]      fstep_q, fstep_d, tgt_q, tgt_d, nxt;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d, dwell_m1, tmr_val;
  logic [1:0]             wave_q, wave_d;
  logic [BIT_DEPTH-1:0]   duty_q, duty_d;
  logic                   up_q, up_d, busy_q, busy_d, done_q, done_d, tick_q, tick_d;
  logic                   tmr_load, tmr_clear, tmr_expire;

  // Counter holds D-1, so a dwell of 0 collapses onto 1.
  assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);

  nco_dwell_timer #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_dwell_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .load    (tmr_load),
    .enable  (state_q == StSweep),
    .load_val(tmr_val),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    freq_d    = freq_q;
    fstart_d  = fstart_q;
    fstop_d   = fstop_q;
    fstep_d   = fstep_q;
    tgt_d     = tgt_q;
    up_d      = up_q;
    dwell_d   = dwell_q;
    wave_d    = wave_q;
    duty_d    = duty_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tick_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_val   = dwell_q;
    nxt       = '0;
    if (abort) begin
      state_d   = StIdle;
      freq_d    = '0;
      busy_d    = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_d   = (mode == 2'b11) ? ModeSingle : mode_e'(mode);
            fstart_d = f_start;
            fstop_d  = f_stop;
            fstep_d  = f_step;
            tgt_d    = f_stop;
            up_d     = (f_stop >= f_start);
            dwell_d  = dwell_m1;
            freq_d   = f_start;
            wave_d   = wave_in;
            duty_d   = duty_in;
            if ((f_step == '0) || (f_start == f_stop)) begin
              done_d = 1'b1;
            end else begin
              state_d  = StSweep;
              busy_d   = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = dwell_m1;
            end
          end
        end
        StSweep: begin
          if (tmr_expire) begin
            tick_d   = 1'b1;
            tmr_load = 1'b1;
            if ((freq_q == tgt_q) && (mode_q == ModeRepeat)) begin
              freq_d = fstart_q;
            end else if ((freq_q == tgt_q) && (mode_q == ModeBounce)) begin
              up_d   = ~up_q;
              tgt_d  = (tgt_q == fstop_q) ? fstart_q : fstop_q;
              freq_d = step_clamp(freq_q, fstep_q, tgt_d, up_d);
            end else begin
              nxt    = step_clamp(freq_q, fstep_q, tgt_q, up_q);
              freq_d = nxt;
              if ((mode_q == ModeSingle) && (nxt == tgt_q)) begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= ModeSingle;
      freq_q   <= '0;
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      tgt_q    <= '0;
      up_q     <= 1'b0;
      dwell_q  <= '0;
      wave_q   <= 2'b00;
      duty_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      freq_q   <= freq_d;
      fstart_q <= fstart_d;
      fstop_q  <= fstop_d;
      fstep_q  <= fstep_d;
      tgt_q    <= tgt_d;
      up_q     <= up_d;
      dwell_q  <= dwell_d;
      wave_q   <= wave_d;
      duty_q   <= duty_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tick_q   <= tick_d;
    end
  end

  assign frequency  = freq_q;
  assign wave       = wave_q;
  assign duty_cycle = duty_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign step_tick  = tick_q;

endmodule
